onehot_range_decoder: RTL and testbench
=======================================

Name: onehot_range_decoder

Overview:
- Reverse side of the leftmost/rightmost-one encoder: accepts a pair of one-hot vectors (left-most and right-most set-bit positions) and recovers the binary indices of both positions.
- Also rebuilds the contiguous span mask between the two positions and flags malformed pairs.
- Sits downstream of the encoder output register, feeding consumers that need indices and span.
- Two-stage registered pipeline with valid/ready backpressure.

Parameters:
- WIDTH, 5, width of one-hot inputs and of mask output (>= 2).
- IDX_W, $clog2(WIDTH), width of index outputs (derived; not overridden).
- ERR_CNT_W, 8, width of saturating error counter (used only with ERR_CNT_EN).

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset, asynchronous, active-low.
- data_left_i  in  WIDTH  one-hot left-most position.
- data_right_i  in  WIDTH  one-hot right-most position.
- data_val_i  in  1  input pair valid.
- data_ready_o  out  1  block can accept input this cycle.
- left_idx_o  out  IDX_W  binary index of left bit.
- right_idx_o  out  IDX_W  binary index of right bit.
- mask_o  out  WIDTH  ones from right_idx_o to left_idx_o inclusive.
- err_o  out  1  pair malformed; qualified by data_val_o.
- data_val_o  out  1  output valid.
- data_ready_i  in  1  downstream accepts output.
- err_cnt_o  out  ERR_CNT_W  error count (present only with ERR_CNT_EN).

Behaviour:
- Reset (arstn_i low, async): both stage valids = 0.
- Reset values: data_val_o = 0, err_o = 0, left_idx_o = 0, right_idx_o = 0, mask_o = 0, err_cnt_o = 0. Data registers also clear.
- Handshake: input transfer when data_val_i && data_ready_o; output transfer when data_val_o && data_ready_i.
- Once data_val_o is high, outputs hold stable until the transfer completes.
- Stage 1: registers the input pair, plus per-vector one-hot check (exactly one bit set).
- Stage 2: priority-encodes each vector to an index, builds mask, computes err.
- Latency: 2 cycles from input transfer to data_val_o with no stall.
- Throughput: 1 pair per cycle.
- Stage advance: stage1 advances when !s2_valid || data_ready_i.
- data_ready_o = !s1_valid || stage1 advances (no bubble at full rate).
- err = 1 if any of:
  - either vector is zero or has more than one bit set;
  - left index < right index;
  - left index == right index (single set bit is not a valid pair, matching the encoder's valid rule).
- When err = 1: data_val_o still asserts; mask_o = 0, left_idx_o = 0, right_idx_o = 0.
- Mask bit i = 1 iff right_idx <= i <= left_idx.
- Simultaneous input and output transfer with both stages full: both stages shift in the same cycle; no loss or duplication.
- data_ready_i low for N cycles: pipeline fills, data_ready_o drops after 2 accepted pairs, and all outputs hold.
- Reset mid-operation: in-flight pairs are discarded and data_val_o falls asynchronously.
- Input data is ignored when data_val_i = 0.

Optional Feature:
- Macro ONEHOT_RANGE_DECODER_ERR_CNT_EN.
- Defined:
  - err_cnt_o port exists.
  - Increments on each output transfer with err_o = 1.
  - Saturates at all-ones; clears only on reset.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Package onehot_range_pkg holds:
  - localparam IDX_W derivation function;
  - typedef dec_result_t struct {left_idx, right_idx, mask, err};
  - function onehot_to_idx (lowest set bit, plus multi-hot detect).
- One natural sub-module: onehot_range_stage, the generic valid/ready pipeline register carrying a payload. Instantiated twice.

Test Plan:
- WIDTH=5, left=5'b10000, right=5'b00010, ready_i=1 -> 2 cycles later data_val_o=1, left_idx=4, right_idx=1, mask=5'b11110, err=0.
- left=5'b00100, right=5'b00100 -> err=1, mask=0; with macro, err_cnt_o=1.
- left=5'b00110 (multi-hot), right=5'b00001 -> err=1. Separately, left=5'b00001, right=5'b01000 -> err=1.
- Back-to-back 8 valid pairs, ready_i toggled 1010... -> all 8 outputs appear in order, none dropped or duplicated; data_ready_o drops only when both stages are full.
- arstn_i pulsed low mid-stream with 2 pairs in flight -> data_val_o=0 immediately and those pairs never emerge; next pair appears 2 cycles after acceptance.
- With macro, ERR_CNT_W=2, 5 error pairs -> err_cnt_o saturates at 3.

Source files
------------

// File: rtl/onehot_range_pkg.sv
// Shared types and helpers for the one-hot range decoder.
// Vectors up to MAX_WIDTH bits are supported.
package onehot_range_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int MAX_IDX_W = 5;

  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  typedef struct packed {
    logic [MAX_IDX_W-1:0] left_idx;
    logic [MAX_IDX_W-1:0] right_idx;
    logic [MAX_WIDTH-1:0] mask;
    logic                 err;
  } dec_result_t;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 zero;
    logic                 multi;
  } onehot_info_t;

  // Lowest set bit wins; any further set bit marks the vector as multi-hot.
  function automatic onehot_info_t onehot_to_idx(input logic [MAX_WIDTH-1:0] vec);
    onehot_info_t info;
    logic         seen;
    info = '0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (vec[i]) begin
        if (seen) info.multi = 1'b1;
        else      info.idx   = MAX_IDX_W'(i);
        seen = 1'b1;
      end
    end
    info.zero = !seen;
    return info;
  endfunction

endpackage

// File: rtl/onehot_range_stage.sv
// Generic valid/ready pipeline register; accepts a new beat whenever it is
// empty or its current beat leaves in the same cycle.
module onehot_range_stage #(
  parameter int DW = 1
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/onehot_range_decoder.sv
// Recovers left/right indices and the span mask from a one-hot pair.
// Define ONEHOT_RANGE_DECODER_ERR_CNT_EN to add the saturating err_cnt_o counter.
module onehot_range_decoder
  import onehot_range_pkg::*;
#(
  parameter  int WIDTH     = 5,
  parameter  int ERR_CNT_W = 8,
  localparam int IDX_W     = idx_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic [WIDTH-1:0]     data_left_i,
  input  logic [WIDTH-1:0]     data_right_i,
  input  logic                 data_val_i,
  output logic                 data_ready_o,
  output logic [IDX_W-1:0]     left_idx_o,
  output logic [IDX_W-1:0]     right_idx_o,
  output logic [WIDTH-1:0]     mask_o,
  output logic                 err_o,
  output logic                 data_val_o,
`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
  input  logic                 data_ready_i
);

  localparam int S1_W = 2 * WIDTH + 2;
  localparam int S2_W = 2 * IDX_W + WIDTH + 1;

  logic             s1_valid;
  logic             s2_ready;
  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_out;
  logic [S2_W-1:0]  s2_in;
  logic [S2_W-1:0]  s2_out;
  logic [WIDTH-1:0] s1_left;
  logic [WIDTH-1:0] s1_right;
  logic             s1_ok_left;
  logic             s1_ok_right;
  onehot_info_t     chk_left;
  onehot_info_t     chk_right;
  onehot_info_t     enc_left;
  onehot_info_t     enc_right;
  dec_result_t      res;
  logic             unused_info;

  always_comb begin
    chk_left  = onehot_to_idx(MAX_WIDTH'(data_left_i));
    chk_right = onehot_to_idx(MAX_WIDTH'(data_right_i));
    s1_in     = {data_left_i, data_right_i,
                 !(chk_left.zero || chk_left.multi),
                 !(chk_right.zero || chk_right.multi)};
  end

  onehot_range_stage #(.DW(S1_W)) u_stage1 (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .in_valid  (data_val_i),
    .in_ready  (data_ready_o),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  assign s1_left     = s1_out[S1_W-1 -: WIDTH];
  assign s1_right    = s1_out[2 +: WIDTH];
  assign s1_ok_left  = s1_out[1];
  assign s1_ok_right = s1_out[0];

  // Equal indices are rejected too: a single set bit is not a valid range.
  always_comb begin
    res       = '0;
    enc_left  = onehot_to_idx(MAX_WIDTH'(s1_left));
    enc_right = onehot_to_idx(MAX_WIDTH'(s1_right));
    res.err   = !s1_ok_left || !s1_ok_right || (enc_left.idx <= enc_right.idx);
    if (!res.err) begin
      res.left_idx  = enc_left.idx;
      res.right_idx = enc_right.idx;
      for (int i = 0; i < WIDTH; i++) begin
        res.mask[i] = (MAX_IDX_W'(i) >= enc_right.idx) && (MAX_IDX_W'(i) <= enc_left.idx);
      end
    end
    s2_in = {IDX_W'(res.left_idx), IDX_W'(res.right_idx), WIDTH'(res.mask), res.err};
  end

  assign unused_info = ^{enc_left.zero, enc_left.multi, enc_right.zero, enc_right.multi,
                         chk_left.idx, chk_right.idx};

  onehot_range_stage #(.DW(S2_W)) u_stage2 (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (data_val_o),
    .out_ready (data_ready_i),
    .out_data  (s2_out)
  );

  assign {left_idx_o, right_idx_o, mask_o, err_o} = s2_out;

`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
  // Counts malformed pairs as they leave; sticks at all-ones until reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_cnt_o <= '0;
    end else if (data_val_o && data_ready_i && err_o && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ERR_CNT_W[0];
`endif

endmodule

// File: tb/tb_onehot_range_decoder.sv
// Directed bench for onehot_range_decoder: vector table plus stall, streaming
// and mid-stream reset sequences.
module tb_onehot_range_decoder;

  localparam int WIDTH = 5;
  localparam int IDX_W = 3;
`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  typedef struct packed {
    logic [IDX_W-1:0] l_idx;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] mask;
    logic             err;
  } exp_t;

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    exp_t             exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             arstn;
  logic [WIDTH-1:0] data_left_i;
  logic [WIDTH-1:0] data_right_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [IDX_W-1:0] left_idx_o;
  logic [IDX_W-1:0] right_idx_o;
  logic [WIDTH-1:0] mask_o;
  logic             err_o;
  logic             data_val_o;
  logic             data_ready_i;
`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_o;
`endif

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  onehot_range_decoder #(.WIDTH(WIDTH), .ERR_CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .left_idx_o   (left_idx_o),
    .right_idx_o  (right_idx_o),
    .mask_o       (mask_o),
    .err_o        (err_o),
    .data_val_o   (data_val_o),
`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
    .err_cnt_o    (err_cnt_o),
`endif
    .data_ready_i (data_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                               input logic val);
    data_left_i  = l;
    data_right_i = r;
    data_val_i   = val;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    check(name, 32'({data_val_o, left_idx_o, right_idx_o, mask_o, err_o}), 32'({1'b1, e}));
  endtask

  task automatic checkCount(input string name);
`ifdef ONEHOT_RANGE_DECODER_ERR_CNT_EN
    check(name, 32'(err_cnt_o), 32'(exp_cnt));
`endif
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    exp_t e;
    int lc, rc, li, ri;
    e = '0; lc = 0; rc = 0; li = 0; ri = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (l[i]) begin lc++; li = i; end
      if (r[i]) begin rc++; ri = i; end
    end
    if (lc == 1 && rc == 1 && li > ri) begin
      e.l_idx = IDX_W'(li);
      e.r_idx = IDX_W'(ri);
      for (int i = 0; i < WIDTH; i++) e.mask[i] = (i >= ri) && (i <= li);
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  vec_t vecs[9];
  exp_t q[$];
  exp_t ea, eb, ec;
  logic [WIDTH-1:0] lp[8];
  logic [WIDTH-1:0] rp[8];
  int li_tab[8] = '{1, 2, 2, 3, 3, 3, 4, 4};
  int ri_tab[8] = '{0, 0, 1, 0, 1, 2, 0, 3};
  logic s1v, s2v, adv1, adv2;
  int sent, recv;

  initial begin
    vecs[0] = '{5'b10000, 5'b00010, '{3'd4, 3'd1, 5'b11110, 1'b0}};
    vecs[1] = '{5'b00100, 5'b00100, '{3'd0, 3'd0, 5'b00000, 1'b1}};
    vecs[2] = '{5'b00110, 5'b00001, '{3'd0, 3'd0, 5'b00000, 1'b1}};
    vecs[3] = '{5'b00001, 5'b01000, '{3'd0, 3'd0, 5'b00000, 1'b1}};
    vecs[4] = '{5'b10000, 5'b00001, '{3'd4, 3'd0, 5'b11111, 1'b0}};
    vecs[5] = '{5'b01000, 5'b00100, '{3'd3, 3'd2, 5'b01100, 1'b0}};
    vecs[6] = '{5'b00000, 5'b00001, '{3'd0, 3'd0, 5'b00000, 1'b1}};
    vecs[7] = '{5'b00010, 5'b00001, '{3'd1, 3'd0, 5'b00011, 1'b0}};
    vecs[8] = '{5'b10000, 5'b11000, '{3'd0, 3'd0, 5'b00000, 1'b1}};

    arstn = 1'b0;
    data_ready_i = 1'b1;
    applyStimulus('0, '0, 1'b0);
    #12;
    check("reset_outputs", 32'({data_val_o, left_idx_o, right_idx_o, mask_o, err_o}), 32'd0);
    check("reset_ready", 32'(data_ready_o), 32'd1);
    checkCount("reset_cnt");
    @(negedge clk) arstn = 1'b1;
    @(posedge clk); #1;

    // Table: one pair at a time, two-cycle latency, drained at full rate.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].left, vecs[i].right, 1'b1);
      @(posedge clk); #1;
      applyStimulus('0, '0, 1'b0);
      check($sformatf("vec%0d_lat1", i), 32'(data_val_o), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      if (vecs[i].exp.err && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end
    @(posedge clk); #1;
    check("table_drained", 32'(data_val_o), 32'd0);
    checkCount("table_cnt");

    // Stall: downstream blocked, two pairs fill the pipe, outputs hold.
    ea = model(5'b01000, 5'b00001);
    eb = model(5'b00100, 5'b00010);
    ec = model(5'b10000, 5'b01000);
    data_ready_i = 1'b0;
    applyStimulus(5'b01000, 5'b00001, 1'b1);
    #1 check("stall_ready0", 32'(data_ready_o), 32'd1);
    @(posedge clk); #1;
    applyStimulus(5'b00100, 5'b00010, 1'b1);
    #1 check("stall_ready1", 32'(data_ready_o), 32'd1);
    @(posedge clk); #1;
    applyStimulus(5'b10000, 5'b01000, 1'b1);
    #1 check("stall_ready_full", 32'(data_ready_o), 32'd0);
    checkOutput("stall_first", ea);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall_hold%0d", k), ea);
      check($sformatf("stall_ready_hold%0d", k), 32'(data_ready_o), 32'd0);
    end
    data_ready_i = 1'b1;
    #1 check("stall_release_ready", 32'(data_ready_o), 32'd1);
    @(posedge clk); #1;
    applyStimulus('0, '0, 1'b0);
    checkOutput("stall_second", eb);
    @(posedge clk); #1;
    checkOutput("stall_third", ec);
    @(posedge clk); #1;
    check("stall_drained", 32'(data_val_o), 32'd0);

    // Streaming: 8 back-to-back pairs with downstream ready toggling 1010...
    for (int k = 0; k < 8; k++) begin
      lp[k] = WIDTH'(1) << li_tab[k];
      rp[k] = WIDTH'(1) << ri_tab[k];
    end
    s1v = 1'b0; s2v = 1'b0; sent = 0; recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      data_ready_i = (cyc % 2 == 0);
      if (sent < 8) applyStimulus(lp[sent], rp[sent], 1'b1);
      else          applyStimulus('0, '0, 1'b0);
      #1;
      adv2 = !s2v || data_ready_i;
      adv1 = !s1v || adv2;
      check($sformatf("stream_ready_c%0d", cyc), 32'(data_ready_o), 32'(adv1));
      check($sformatf("stream_val_c%0d", cyc), 32'(data_val_o), 32'(s2v));
      if (s2v && data_ready_i) begin
        if (q.size() > 0) checkOutput($sformatf("stream_out%0d", recv), q.pop_front());
        recv++;
      end
      if (data_val_i && adv1) begin
        q.push_back(model(lp[sent], rp[sent]));
        sent++;
      end
      s2v = adv2 ? s1v : s2v;
      s1v = adv1 ? data_val_i : s1v;
      @(posedge clk); #1;
    end
    applyStimulus('0, '0, 1'b0);
    data_ready_i = 1'b1;
    check("stream_recv", 32'(recv), 32'd8);
    check("stream_queue_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with two pairs in flight: they must vanish.
    data_ready_i = 1'b0;
    applyStimulus(5'b01000, 5'b00001, 1'b1);
    @(posedge clk); #1;
    applyStimulus(5'b00100, 5'b00010, 1'b1);
    @(posedge clk); #1;
    applyStimulus('0, '0, 1'b0);
    check("rst_pre_val", 32'(data_val_o), 32'd1);
    #2 arstn = 1'b0;
    #1;
    check("rst_async_val", 32'(data_val_o), 32'd0);
    check("rst_async_mask", 32'(mask_o), 32'd0);
    check("rst_async_ready", 32'(data_ready_o), 32'd1);
    exp_cnt = 0;
    checkCount("rst_cnt");
    @(negedge clk) arstn = 1'b1;
    data_ready_i = 1'b1;
    @(posedge clk); #1;
    applyStimulus(5'b10000, 5'b01000, 1'b1);
    @(posedge clk); #1;
    applyStimulus('0, '0, 1'b0);
    check("rst_lat1", 32'(data_val_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_new_pair", ec);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_ghost%0d", k), 32'(data_val_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
